landing_clearance_unit: RTL
===========================

Name: landing_clearance_unit

Overview:
- Consumer of the weather control unit's outputs (ECSU_state, severe_weather, emergency_landing_alert) on the runway side.
- Queues landing and takeoff requests and issues one-at-a-time runway grants.
- Grants are gated by current weather severity; landings have priority over takeoffs.
- Tracks runway occupancy and times out aircraft that never report clear.

Parameters:
- QW, 4: width of each request queue counter (max 2^QW-1 pending).
- RUNWAY_TIMEOUT, 50: cycles a granted operation may occupy the runway before fault.
- DEBOUNCE_CYCLES, 3: stability window for ECSU_state (only used with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- ECSU_state  in  2  weather state: 00 ALL_CLEAR, 01 CAUTION, 10 HIGH_ALERT, 11 EMERGENCY.
- severe_weather  in  1  severe weather flag.
- emergency_landing_alert  in  1  emergency landing request from weather unit.
- landing_req  in  1  one-cycle pulse per arriving aircraft.
- takeoff_req  in  1  one-cycle pulse per departing aircraft.
- runway_clear  in  1  one-cycle pulse: runway vacated.
- landing_grant  out  1  one-cycle pulse, registered.
- takeoff_grant  out  1  one-cycle pulse, registered.
- runway_busy  out  1  high when state != IDLE.
- land_pending  out  QW  queued landings.
- takeoff_pending  out  QW  queued takeoffs.
- queue_overflow  out  1  sticky; a request was dropped at saturation.
- runway_fault  out  1  sticky; occupancy timeout occurred.
- lcu_state  out  2  00 IDLE, 01 LANDING, 10 TAKEOFF, 11 FAULT.

Behaviour:
- Reset, synchronous on a CLK edge with RST=1: all outputs 0, both queues 0, lcu_state IDLE, timer 0, eff_state ALL_CLEAR.
- Gating:
  - land_ok = (eff_state==ALL_CLEAR) | (eff_state==CAUTION) | emergency_landing_alert.
  - takeoff_ok = (eff_state==ALL_CLEAR) & !severe_weather.
- Queues:
  - A request pulse sampled at edge n increments the queue at edge n.
  - A grant decrements its queue at the same edge the grant is registered.
  - Request and grant at the same edge: count unchanged.
  - Request at max count: request dropped, queue_overflow set and held until RST.
  - No decrement below 0; grants require count>0.
- FSM, evaluated each edge using registered queue values:
  - IDLE: if land_pending>0 & land_ok, go to LANDING and pulse landing_grant. Otherwise, if takeoff_pending>0 & takeoff_ok, go to TAKEOFF and pulse takeoff_grant. Otherwise stay in IDLE. runway_clear is ignored in IDLE.
  - LANDING/TAKEOFF: timer counts from 0. On runway_clear, return to IDLE and clear the timer. When timer reaches RUNWAY_TIMEOUT-1 without runway_clear, go to FAULT and set runway_fault (sticky).
  - runway_clear and timeout at the same edge: runway_clear wins, go to IDLE.
  - A weather change mid-operation does not abort the operation.
  - FAULT: no grants; queues still accept requests. runway_clear returns to IDLE.
- Latency: a request at edge n gives a grant pulse visible after edge n+1 at the earliest.
- Grant spacing: at most one grant outstanding at a time; the next grant comes no earlier than one edge after runway_clear.
- Without the optional feature, eff_state = ECSU_state (combinational, zero latency).

Optional Feature:
- Macro: LCU_WEATHER_DEBOUNCE_EN.
- Defined:
  - eff_state is a register, updated to ECSU_state only after ECSU_state has held the same value for DEBOUNCE_CYCLES consecutive edges.
  - Any change restarts the stability count.
  - emergency_landing_alert bypasses debounce and still enables landings immediately.
  - Reset loads eff_state with ALL_CLEAR.
- Undefined: no debounce logic or counter; eff_state follows ECSU_state directly.

Decomposition:
- Package atc_pkg:
  - ECSU state encodings (ALL_CLEAR, CAUTION, HIGH_ALERT, EMERGENCY).
  - lcu_state encodings (IDLE, LANDING, TAKEOFF, FAULT).
  - Default QW and RUNWAY_TIMEOUT.
- Sub-module sat_queue_counter: saturating up/down counter with inc, dec, count, overflow-sticky outputs. Instantiated twice, once per queue.

Test Plan:
- ALL_CLEAR, landing_req at edge 2 -> land_pending=1 at edge 2; landing_grant pulse after edge 3; lcu_state=01; runway_clear at edge 6 -> IDLE, land_pending=0.
- HIGH_ALERT, severe_weather=1, one landing_req and one takeoff_req -> no grants for 20 cycles. Switch to CAUTION -> landing_grant only, takeoff stays pending until ALL_CLEAR & !severe_weather.
- HIGH_ALERT with emergency_landing_alert=1 and land_pending=2 -> landing_grant issued despite HIGH_ALERT.
- QW=4: 16 landing_req pulses with land_ok=0 -> land_pending=15, queue_overflow=1. Simultaneous request and grant -> count unchanged.
- RUNWAY_TIMEOUT=50, grant with no runway_clear -> FAULT and runway_fault=1 at edge 50 after grant. runway_clear -> IDLE, runway_fault stays 1 until RST. RST mid-LANDING -> all outputs 0 next edge.
- With LCU_WEATHER_DEBOUNCE_EN, DEBOUNCE_CYCLES=3: ECSU_state glitch to HIGH_ALERT for 2 cycles -> takeoff grants unaffected; held 3 cycles -> takeoffs blocked.

Source files
------------

// File: rtl/atc_pkg.sv
// Shared encodings and default sizing for the runway-side air traffic control blocks.
package atc_pkg;

  typedef enum logic [1:0] {
    ECSU_ALL_CLEAR  = 2'b00,
    ECSU_CAUTION    = 2'b01,
    ECSU_HIGH_ALERT = 2'b10,
    ECSU_EMERGENCY  = 2'b11
  } ecsu_e;

  typedef enum logic [1:0] {
    LCU_IDLE    = 2'b00,
    LCU_LANDING = 2'b01,
    LCU_TAKEOFF = 2'b10,
    LCU_FAULT   = 2'b11
  } lcu_state_e;

  localparam int unsigned QW_DEF              = 4;
  localparam int unsigned RUNWAY_TIMEOUT_DEF  = 50;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 3;

endpackage

// File: rtl/sat_queue_counter.sv
// Saturating pending-request counter; simultaneous inc/dec cancel, an inc at full
// is dropped and latches overflow until reset.
module sat_queue_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end else if (!inc_i && dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/landing_clearance_unit.sv
// Runway grant arbiter: weather-gated, landings before takeoffs, one operation at a time
// with occupancy timeout. Define LCU_WEATHER_DEBOUNCE_EN to debounce ECSU_state.
module landing_clearance_unit
  import atc_pkg::*;
#(
  parameter int unsigned QW              = QW_DEF,
  parameter int unsigned RUNWAY_TIMEOUT  = RUNWAY_TIMEOUT_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    ECSU_state,
  input  logic          severe_weather,
  input  logic          emergency_landing_alert,
  input  logic          landing_req,
  input  logic          takeoff_req,
  input  logic          runway_clear,
  output logic          landing_grant,
  output logic          takeoff_grant,
  output logic          runway_busy,
  output logic [QW-1:0] land_pending,
  output logic [QW-1:0] takeoff_pending,
  output logic          queue_overflow,
  output logic          runway_fault,
  output logic [1:0]    lcu_state
);

  localparam int unsigned TW = (RUNWAY_TIMEOUT > 2) ? $clog2(RUNWAY_TIMEOUT) : 1;

  if (RUNWAY_TIMEOUT < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("landing_clearance_unit: RUNWAY_TIMEOUT must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  ecsu_e eff_state;

`ifdef LCU_WEATHER_DEBOUNCE_EN
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

  ecsu_e          eff_q, cand_q;
  logic [DCW-1:0] stab_q, stab_d;

  // stab counts consecutive edges on which ECSU_state matched the previous sample
  always_comb begin
    stab_d = DCW'(1);
    if (ECSU_state == cand_q)
      stab_d = (stab_q == DCW'(DEBOUNCE_CYCLES)) ? stab_q : stab_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      eff_q  <= ECSU_ALL_CLEAR;
      cand_q <= ECSU_ALL_CLEAR;
      stab_q <= DCW'(DEBOUNCE_CYCLES);
    end else begin
      cand_q <= ecsu_e'(ECSU_state);
      stab_q <= stab_d;
      if (stab_d == DCW'(DEBOUNCE_CYCLES)) eff_q <= ecsu_e'(ECSU_state);
    end
  end

  assign eff_state = eff_q;
`else
  assign eff_state = ecsu_e'(ECSU_state);
`endif

  logic land_ok, takeoff_ok;
  assign land_ok    = (eff_state == ECSU_ALL_CLEAR) || (eff_state == ECSU_CAUTION)
                   || emergency_landing_alert;
  assign takeoff_ok = (eff_state == ECSU_ALL_CLEAR) && !severe_weather;

  lcu_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fault_q, fault_d;
  logic          lgnt_q, lgnt_d;
  logic          tgnt_q, tgnt_d;
  logic          land_ovf, take_ovf;

  sat_queue_counter #(.W(QW)) u_land_q (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (landing_req),
    .dec_i      (lgnt_d),
    .count_o    (land_pending),
    .overflow_o (land_ovf)
  );

  sat_queue_counter #(.W(QW)) u_take_q (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (takeoff_req),
    .dec_i      (tgnt_d),
    .count_o    (takeoff_pending),
    .overflow_o (take_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LCU_IDLE;
      timer_q <= '0;
      fault_q <= 1'b0;
      lgnt_q  <= 1'b0;
      tgnt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
      lgnt_q  <= lgnt_d;
      tgnt_q  <= tgnt_d;
    end
  end

  // Operation in progress is never aborted by weather; clear beats timeout.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    fault_d = fault_q;
    case (state_q)
      LCU_IDLE: begin
        if (lgnt_d)      state_d = LCU_LANDING;
        else if (tgnt_d) state_d = LCU_TAKEOFF;
      end
      LCU_LANDING, LCU_TAKEOFF: begin
        if (runway_clear) begin
          state_d = LCU_IDLE;
        end else if (timer_q == TW'(RUNWAY_TIMEOUT - 1)) begin
          state_d = LCU_FAULT;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LCU_FAULT: begin
        if (runway_clear) state_d = LCU_IDLE;
      end
      default: state_d = LCU_IDLE;
    endcase
  end

  always_comb begin
    lgnt_d = 1'b0;
    tgnt_d = 1'b0;
    if (state_q == LCU_IDLE) begin
      if ((land_pending != '0) && land_ok)            lgnt_d = 1'b1;
      else if ((takeoff_pending != '0) && takeoff_ok) tgnt_d = 1'b1;
    end
  end

  assign landing_grant  = lgnt_q;
  assign takeoff_grant  = tgnt_q;
  assign runway_busy    = (state_q != LCU_IDLE);
  assign queue_overflow = land_ovf | take_ovf;
  assign runway_fault   = fault_q;
  assign lcu_state      = state_q;

endmodule
